// File: rtl/angle_nco.sv
// Phase-accumulator NCO producing a time-aligned angle/sin/cos sample stream, two cycles after the accumulator.
// Define ANGLE_NCO_QUARTER_WAVE_EN to fold one quarter-wave table instead of full sin/cos tables.
module angle_nco #(
    parameter int ACC_WIDTH    = 32,
    parameter int ANGLE_WIDTH  = 12,
    parameter int SINCOS_WIDTH = 16
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic                           dir,
    input  logic [ACC_WIDTH-1:0]           freq_word,
    input  logic [ANGLE_WIDTH-1:0]         phase_offset,
    input  logic                           load,
    input  logic [ANGLE_WIDTH-1:0]         load_angle,
    output logic [ANGLE_WIDTH-1:0]         angle,
    output logic signed [SINCOS_WIDTH-1:0] sin,
    output logic signed [SINCOS_WIDTH-1:0] cos,
    output logic                           valid,
    output logic                           wrap
);

    localparam int  N    = 2 ** ANGLE_WIDTH;
    localparam int  Q    = 2 ** (ANGLE_WIDTH - 2);
    localparam int  FRAC = ACC_WIDTH - ANGLE_WIDTH;
    localparam real PI   = 3.14159265358979323846;
    localparam real AMP  = real'(2 ** (SINCOS_WIDTH - 1) - 1);

    // The ROM contents follow the rounded-sine rule and are built at elaboration, so no image files are needed.
    // Both builds derive every entry from this single quarter-wave function, keeping them bit-identical.
    function automatic logic signed [SINCOS_WIDTH-1:0] quarter_val(input int i);
        real x;
        x = AMP * $sin(PI / 2.0 * real'(i) / real'(Q));
        return SINCOS_WIDTH'($rtoi(x + 0.5));
    endfunction

    logic [ACC_WIDTH-1:0]           r_acc;
    logic                           r_vld0;
    logic                           r_wrap0;
    logic [ANGLE_WIDTH-1:0]         r_aint;
    logic                           r_vld1;
    logic                           r_wrap1;
    logic [ACC_WIDTH:0]             w_sum;
    logic [ACC_WIDTH:0]             w_diff;
    logic signed [SINCOS_WIDTH-1:0] w_sin;
    logic signed [SINCOS_WIDTH-1:0] w_cos;

    // The extra MSB carries the carry-out (add) or borrow (subtract) that marks a full-turn crossing.
    assign w_sum  = {1'b0, r_acc} + {1'b0, freq_word};
    assign w_diff = {1'b0, r_acc} - {1'b0, freq_word};

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_acc   <= '0;
            r_vld0  <= 1'b0;
            r_wrap0 <= 1'b0;
        end else if (load) begin
            r_acc   <= {load_angle, {FRAC{1'b0}}};
            r_vld0  <= 1'b1;
            r_wrap0 <= 1'b0;
        end else if (enable) begin
            r_vld0 <= 1'b1;
            if (!dir) begin
                r_acc   <= w_sum[ACC_WIDTH-1:0];
                r_wrap0 <= w_sum[ACC_WIDTH];
            end else begin
                r_acc   <= w_diff[ACC_WIDTH-1:0];
                r_wrap0 <= w_diff[ACC_WIDTH];
            end
        end else begin
            r_vld0  <= 1'b0;
            r_wrap0 <= 1'b0;
        end
    end

    // Data registers only capture valid samples so outputs hold while the accumulator is idle.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_aint  <= '0;
            r_vld1  <= 1'b0;
            r_wrap1 <= 1'b0;
            angle   <= '0;
            sin     <= '0;
            cos     <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            r_vld1  <= r_vld0;
            r_wrap1 <= r_wrap0;
            valid   <= r_vld1;
            wrap    <= r_wrap1;
            if (r_vld0) begin
                r_aint <= r_acc[ACC_WIDTH-1 -: ANGLE_WIDTH] + phase_offset;
            end
            if (r_vld1) begin
                angle <= r_aint;
                sin   <= w_sin;
                cos   <= w_cos;
            end
        end
    end

`ifdef ANGLE_NCO_QUARTER_WAVE_EN
    logic signed [SINCOS_WIDTH-1:0] w_qtab [Q+1];
    logic [ANGLE_WIDTH-1:0]         w_cos_ang;
    logic signed [SINCOS_WIDTH-1:0] w_sin_mag;
    logic signed [SINCOS_WIDTH-1:0] w_cos_mag;

    for (genvar g = 0; g <= Q; g++) begin : g_qrom
        assign w_qtab[g] = quarter_val(g);
    end

    // Odd quadrants read the table mirrored; the upper half-turn negates.
    function automatic logic [ANGLE_WIDTH-2:0] fold_idx(input logic [ANGLE_WIDTH-1:0] a);
        if (a[ANGLE_WIDTH-2]) begin
            return (ANGLE_WIDTH-1)'(Q) - {1'b0, a[ANGLE_WIDTH-3:0]};
        end
        return {1'b0, a[ANGLE_WIDTH-3:0]};
    endfunction

    assign w_cos_ang = r_aint + ANGLE_WIDTH'(Q);
    assign w_sin_mag = w_qtab[fold_idx(r_aint)];
    assign w_cos_mag = w_qtab[fold_idx(w_cos_ang)];
    assign w_sin     = r_aint[ANGLE_WIDTH-1]    ? -w_sin_mag : w_sin_mag;
    assign w_cos     = w_cos_ang[ANGLE_WIDTH-1] ? -w_cos_mag : w_cos_mag;
`else
    logic signed [SINCOS_WIDTH-1:0] w_sin_tab [N];
    logic signed [SINCOS_WIDTH-1:0] w_cos_tab [N];

    function automatic logic signed [SINCOS_WIDTH-1:0] full_val(input int a);
        logic signed [SINCOS_WIDTH-1:0] r;
        int i;
        i = a % Q;
        case ((a / Q) % 4)
            0:       r = quarter_val(i);
            1:       r = quarter_val(Q - i);
            2:       r = -quarter_val(i);
            default: r = -quarter_val(Q - i);
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign w_sin_tab[g] = full_val(g);
        assign w_cos_tab[g] = full_val((g + Q) % N);
    end

    assign w_sin = w_sin_tab[r_aint];
    assign w_cos = w_cos_tab[r_aint];
`endif

endmodule

// File: tb/tb_angle_nco.sv
// Scoreboard bench for angle_nco: a spec-level model queues expected samples, a negedge monitor checks them.
module tb_angle_nco;

    localparam real PI = 3.14159265358979323846;

    logic               aclk = 1'b0;
    logic               resetn = 1'b0;
    logic               enable = 1'b0;
    logic               dir = 1'b0;
    logic [31:0]        freq_word = '0;
    logic [11:0]        phase_offset = '0;
    logic               load = 1'b0;
    logic [11:0]        load_angle = '0;
    logic [11:0]        angle;
    logic signed [15:0] sin;
    logic signed [15:0] cos;
    logic               valid;
    logic               wrap;

    angle_nco dut (
        .aclk(aclk), .resetn(resetn), .enable(enable), .dir(dir),
        .freq_word(freq_word), .phase_offset(phase_offset),
        .load(load), .load_angle(load_angle),
        .angle(angle), .sin(sin), .cos(cos), .valid(valid), .wrap(wrap)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int ang;
        int s;
        int c;
        int w;
    } samp_t;

    samp_t sb_q[$];
    samp_t last_s;
    samp_t mon_e;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    // Model state: full-turn accumulator as a plain number, plus flags of the last written value.
    longint m_acc = 0;
    bit     m_v = 1'b0;
    bit     m_w = 1'b0;

    function automatic int exp_sin(input int a);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(a) / 4096.0);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst_n, input bit ld, input bit en, input bit d,
                        input logic [31:0] fw, input logic [11:0] po, input logic [11:0] la);
        samp_t s;
        int a;
        resetn = rst_n; load = ld; enable = en; dir = d;
        freq_word = fw; phase_offset = po; load_angle = la;
        if (rst_n) begin
            if (m_v) begin
                a = int'((m_acc / 64'd1048576 + longint'(po)) % 64'd4096);
                s.ang = a;
                s.s = exp_sin(a);
                s.c = exp_sin((a + 1024) % 4096);
                s.w = int'(m_w);
                sb_q.push_back(s);
            end
            if (ld) begin
                m_acc = longint'(la) * 64'd1048576;
                m_v = 1'b1; m_w = 1'b0;
            end else if (en) begin
                m_v = 1'b1;
                if (!d) begin
                    m_acc = m_acc + longint'(fw);
                    m_w = (m_acc >= 64'h1_0000_0000);
                    if (m_w) m_acc = m_acc - 64'h1_0000_0000;
                end else begin
                    m_w = (longint'(fw) > m_acc);
                    m_acc = m_acc - longint'(fw);
                    if (m_w) m_acc = m_acc + 64'h1_0000_0000;
                end
            end else begin
                m_v = 1'b0; m_w = 1'b0;
            end
        end
        @(posedge aclk);
        #1;
        if (!rst_n) begin
            sb_q.delete();
            m_acc = 0; m_v = 1'b0; m_w = 1'b0;
            last_s = '{0, 0, 0, 0};
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_angle"}, angle, 0);
        check({tag, "_sin"}, sin, 0);
        check({tag, "_cos"}, cos, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_wrap"}, wrap, 0);
    endtask

    // Monitor: pops on every valid sample; while idle, outputs must hold the last sample.
    always @(negedge aclk) begin
        if (mon_en) begin
            if (valid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected actual=valid expected=no_sample at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("angle", angle, mon_e.ang);
                    check("sin", sin, mon_e.s);
                    check("cos", cos, mon_e.c);
                    check("wrap", wrap, mon_e.w);
                    last_s = mon_e;
                end
            end else begin
                check("hold_angle", angle, last_s.ang);
                check("hold_sin", sin, last_s.s);
                check("hold_cos", cos, last_s.c);
                check("idle_wrap", wrap, 0);
            end
        end
    end

    initial begin
        logic [31:0] fw;
        logic [11:0] po;
        bit          d;
        last_s = '{0, 0, 0, 0};

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check_zero("reset");
        mon_en = 1'b1;

        // Exhaustive sweep: every angle once, wrap aligned with angle 0.
        step(1, 1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4100; n++) step(1, 0, 1, 0, 32'h0010_0000, 0, 0);

        // Half-speed run through the quadrant points.
        step(1, 1, 0, 0, 0, 0, 12'd1020);
        for (int n = 0; n < 2200; n++) step(1, 0, 1, 0, 32'h0008_0000, 0, 0);

        // Reverse through zero.
        step(1, 1, 0, 0, 0, 0, 12'd2);
        for (int n = 0; n < 6; n++) step(1, 0, 1, 1, 32'h0010_0000, 0, 0);

        // Load while enabled, then continue stepping.
        step(1, 1, 1, 0, 32'h0010_0000, 0, 12'd1000);
        for (int n = 0; n < 6; n++) step(1, 0, 1, 0, 32'h0010_0000, 0, 0);

        // Frozen accumulator with a quarter-turn offset.
        step(1, 1, 0, 0, 0, 12'd1024, 12'd0);
        for (int n = 0; n < 5; n++) step(1, 0, 0, 0, 0, 12'd1024, 0);
        check("po_angle", angle, 1024);
        check("po_sin", sin, 32767);
        check("po_cos", cos, 0);
        check("po_valid", valid, 0);

        // Randomised traffic with a one-cycle reset in the middle.
        fw = 32'h0010_0000; po = '0; d = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                d = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: fw = $urandom;
                    1: fw = 32'h0010_0000;
                    2: fw = 32'h0;
                    3: fw = 32'hFFFF_FFFF - $urandom_range(0, 32'h0020_0000);
                    default: fw = $urandom_range(1, 32'h0004_0000);
                endcase
            end
            if ($urandom_range(0, 7) == 0) po = 12'($urandom_range(0, 4095));
            if (n == 1500) begin
                step(0, 0, 1, d, fw, po, 0);
                check_zero("midrst");
            end else begin
                step(1, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), d, fw, po,
                     12'($urandom_range(0, 4095)));
            end
        end

        for (int n = 0; n < 4; n++) step(1, 0, 0, 0, 0, po, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
